// File: rtl/column_writer.sv
// Column writer: takes one DDA ray result per column and paints a full
// vertical strip of the framebuffer (ceiling, wall slice, floor), one
// pixel per pixel_clk_in cycle, then pulses frame_done_out after the
// last ray of a frame.
module column_writer #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 180,
    parameter logic [15:0] CEIL_COLOR    = 16'h4208,
    parameter logic [15:0] FLOOR_COLOR   = 16'h8410
) (
    input  logic                                           pixel_clk_in,
    input  logic                                           rst_in,
    input  logic                                           dda_fifo_tvalid,
    input  logic [37:0]                                    dda_fifo_tdata,
    input  logic                                           dda_fifo_tlast,
    output logic                                           dda_fifo_tready,
    output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0]  fb_addr_out,
    output logic [15:0]                                    fb_data_out,
    output logic                                           fb_we_out,
    output logic                                           frame_done_out,
    output logic                                           busy_out
);

    // state | meaning
    // IDLE  | waiting for a ray entry, tready high
    // SETUP | entry latched, first row prepared
    // DRAW  | one framebuffer write per cycle, row 0..SCREEN_HEIGHT-1
    // DONE  | single-cycle frame_done_out after the frame's last ray

    localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int ROW_W  = $clog2(SCREEN_HEIGHT);

    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(SCREEN_HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  ROW_STEP  = ADDR_W'(SCREEN_WIDTH);
    localparam logic [9:0]         WIDTH_LIM = 10'(SCREEN_WIDTH);
    localparam logic signed [15:0] MID_ROW   = 16'(SCREEN_HEIGHT / 2);
    localparam logic signed [15:0] HEIGHT_S  = 16'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t              state_q, state_d;
    logic [8:0]          hcount_q;
    logic [7:0]          height_q;
    logic                wall_type_q;
    logic [2:0]          map_q;
    logic                last_q;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                emit;
    logic                col_valid;
    logic signed [15:0]  half_s, start_raw, end_raw, wall_start, wall_end, row_s;
    logic [15:0]         palette_color, wall_color, pixel;

    // wallX and mapData[3] carry no meaning for this renderer
    logic unused_bits;
    assign unused_bits = ^{dda_fifo_tdata[15:0], dda_fifo_tdata[19], height_q[0]};

    function automatic logic [15:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 16'hF81F;
            3'd1:    palette = 16'hF800;
            3'd2:    palette = 16'h07E0;
            3'd3:    palette = 16'h001F;
            3'd4:    palette = 16'hFFFF;
            3'd5:    palette = 16'hFFE0;
            3'd6:    palette = 16'h07FF;
            default: palette = 16'h8410;
        endcase
    endfunction

    assign dda_fifo_tready = (state_q == IDLE);
    assign busy_out        = (state_q != IDLE);
    assign frame_done_out  = (state_q == DONE);
    assign col_valid       = ({1'b0, hcount_q} < WIDTH_LIM);

    // Wall bounds depend only on the latched height, so they are stable from
    // SETUP onward; signed 16-bit math lets tall walls clamp instead of wrap.
    always_comb begin
        half_s     = $signed({9'd0, height_q[7:1]});
        start_raw  = MID_ROW - half_s;
        end_raw    = MID_ROW + half_s;
        wall_start = (start_raw < 16'sd0) ? 16'sd0 : start_raw;
        wall_end   = (end_raw > HEIGHT_S) ? HEIGHT_S : end_raw;
    end

    // Colour of the row about to be registered onto the framebuffer port.
    always_comb begin
        row_s         = $signed(16'(row_d));
        palette_color = palette(map_q);
        wall_color    = wall_type_q ? ((palette_color >> 1) & 16'h7BEF) : palette_color;
        if (row_s < wall_start) begin
            pixel = CEIL_COLOR;
        end else if (row_s >= wall_end) begin
            pixel = FLOOR_COLOR;
        end else begin
            pixel = wall_color;
        end
    end

    // Next-state logic; emit marks a row to be registered onto the write port.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        base_d  = base_q;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dda_fifo_tvalid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = DRAW;
                row_d   = '0;
                base_d  = '0;
                emit    = 1'b1;
            end
            DRAW: begin
                if (row_q == LAST_ROW) begin
                    state_d = last_q ? DONE : IDLE;
                end else begin
                    row_d  = row_q + ROW_W'(1);
                    base_d = base_q + ROW_STEP;
                    emit   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched ray fields and the registered framebuffer write port.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            hcount_q    <= '0;
            height_q    <= '0;
            wall_type_q <= 1'b0;
            map_q       <= '0;
            last_q      <= 1'b0;
            row_q       <= '0;
            base_q      <= '0;
            fb_we_out   <= 1'b0;
            fb_addr_out <= '0;
            fb_data_out <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            base_q  <= base_d;
            if (state_q == IDLE && dda_fifo_tvalid) begin
                hcount_q    <= dda_fifo_tdata[37:29];
                height_q    <= dda_fifo_tdata[28:21];
                wall_type_q <= dda_fifo_tdata[20];
                map_q       <= dda_fifo_tdata[18:16];
                last_q      <= dda_fifo_tlast;
            end
            fb_we_out <= emit && col_valid;
            if (emit && col_valid) begin
                fb_addr_out <= base_d + ADDR_W'(hcount_q);
                fb_data_out <= pixel;
            end
        end
    end

endmodule

// File: tb/tb_column_writer.sv
// Directed bench for column_writer: drives ray entries and compares the
// resulting column writes, timing and frame pulses with hand-worked values.
module tb_column_writer;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    logic        dda_fifo_tvalid;
    logic [37:0] dda_fifo_tdata;
    logic        dda_fifo_tlast;
    logic        dda_fifo_tready;
    logic [15:0] fb_addr_out;
    logic [15:0] fb_data_out;
    logic        fb_we_out;
    logic        frame_done_out;
    logic        busy_out;

    column_writer dut (
        .pixel_clk_in    (pixel_clk_in),
        .rst_in          (rst_in),
        .dda_fifo_tvalid (dda_fifo_tvalid),
        .dda_fifo_tdata  (dda_fifo_tdata),
        .dda_fifo_tlast  (dda_fifo_tlast),
        .dda_fifo_tready (dda_fifo_tready),
        .fb_addr_out     (fb_addr_out),
        .fb_data_out     (fb_data_out),
        .fb_we_out       (fb_we_out),
        .frame_done_out  (frame_done_out),
        .busy_out        (busy_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    int cyc = 0;
    always @(posedge pixel_clk_in) cyc <= cyc + 1;

    logic [15:0] wr_data [0:4095];
    logic [15:0] wr_addr [0:4095];
    int          wr_cyc  [0:4095];
    int          wr_total   = 0;
    int          done_total = 0;
    int          done_cyc   = 0;

    // write/pulse log, sampled mid-cycle
    always @(negedge pixel_clk_in) begin
        if (fb_we_out && wr_total < 4096) begin
            wr_data[wr_total] = fb_data_out;
            wr_addr[wr_total] = fb_addr_out;
            wr_cyc[wr_total]  = cyc;
            wr_total          = wr_total + 1;
        end
        if (frame_done_out) begin
            done_total = done_total + 1;
            done_cyc   = cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int h, input int lh, input int wt, input int md, input int last,
                        output int t_acc);
        @(negedge pixel_clk_in);
        dda_fifo_tdata  = {9'(h), 8'(lh), 1'(wt), 4'(md), 16'($urandom)};
        dda_fifo_tlast  = 1'(last);
        dda_fifo_tvalid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (dda_fifo_tready) begin
                t_acc = cyc;
                break;
            end
            @(negedge pixel_clk_in);
        end
        if (t_acc < 0) check("accept_timeout", 0, 1);
        @(negedge pixel_clk_in);
        dda_fifo_tvalid = 1'b0;
        dda_fifo_tlast  = 1'b0;
    endtask

    task automatic wait_idle(output int t_idle);
        t_idle = -1;
        for (int i = 0; i < 400; i++) begin
            if (dda_fifo_tready) begin
                t_idle = cyc;
                break;
            end
            @(negedge pixel_clk_in);
        end
        if (t_idle < 0) check("idle_timeout", 0, 1);
    endtask

    // one column; ws/we/wall are the hand-worked wall rows and wall colour
    task automatic run_col(input string tag, input int h, input int lh, input int wt, input int md,
                           input int last, input int ws, input int we, input logic [15:0] wall);
        int base, dbase, t, t_idle, n;
        logic [15:0] exp;
        base  = wr_total;
        dbase = done_total;
        send(h, lh, wt, md, last, t);
        wait_idle(t_idle);
        n = wr_total - base;
        check({tag, "_idle_cyc"}, t_idle - t, last ? 183 : 182);
        check({tag, "_done_cnt"}, done_total - dbase, last ? 1 : 0);
        if (last) check({tag, "_done_cyc"}, done_cyc - t, 182);
        if (h >= 320) begin
            check({tag, "_wr_cnt"}, n, 0);
        end else begin
            check({tag, "_wr_cnt"}, n, 180);
            check({tag, "_first_cyc"}, wr_cyc[base] - t, 2);
            check({tag, "_last_cyc"}, wr_cyc[base + 179] - t, 181);
            for (int v = 0; v < 180; v++) begin
                exp = (v < ws) ? 16'h4208 : (v >= we) ? 16'h8410 : wall;
                check($sformatf("%s_data_r%0d", tag, v), wr_data[base + v], exp);
                check($sformatf("%s_addr_r%0d", tag, v), wr_addr[base + v], h + 320 * v);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, base, dbase, k;
        int acc [0:2];
        rst_in          = 1'b1;
        dda_fifo_tvalid = 1'b0;
        dda_fifo_tdata  = '0;
        dda_fifo_tlast  = 1'b0;
        repeat (3) @(negedge pixel_clk_in);
        check("rst_we",   fb_we_out, 0);
        check("rst_done", frame_done_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_addr", fb_addr_out, 0);
        check("rst_data", fb_data_out, 0);
        rst_in = 1'b0;
        @(negedge pixel_clk_in);
        check("rst_tready", dda_fifo_tready, 1);

        run_col("basic",  10,  60, 0, 1,    0, 60, 120, 16'hF800);
        check("hold_we",   fb_we_out, 0);
        check("hold_addr", fb_addr_out, 10 + 320 * 179);
        check("hold_data", fb_data_out, 16'h8410);
        run_col("dark",   10,  60, 1, 4,    0, 60, 120, 16'h7BEF);
        run_col("lh0",    10,   0, 0, 2,    0, 90,  90, 16'h07E0);
        run_col("lh255",  11, 255, 1, 4'hB, 0,  0, 180, 16'h000F);
        run_col("lh61",   10,  61, 0, 1,    0, 60, 120, 16'hF800);
        run_col("pal0",   42, 100, 0, 0,    0, 40, 140, 16'hF81F);
        run_col("pal7d",  43, 100, 1, 7,    0, 40, 140, 16'h4208);
        run_col("h319",  319,  60, 0, 6,    1, 60, 120, 16'h07FF);
        check("h319_last_addr", wr_addr[wr_total - 1], 57599);
        run_col("h320",  320,  60, 0, 6,    1, 60, 120, 16'h07FF);

        // tvalid held across three entries
        base = wr_total;
        @(negedge pixel_clk_in);
        dda_fifo_tdata  = {9'd20, 8'd60, 1'b0, 4'd1, 16'h1234};
        dda_fifo_tlast  = 1'b0;
        dda_fifo_tvalid = 1'b1;
        k = 0;
        for (int i = 0; i < 1000 && k < 3; i++) begin
            if (dda_fifo_tready) begin
                acc[k] = cyc;
                k++;
            end
            @(negedge pixel_clk_in);
        end
        dda_fifo_tvalid = 1'b0;
        check("b2b_accepts", k, 3);
        check("b2b_gap1", acc[1] - acc[0], 182);
        check("b2b_gap2", acc[2] - acc[1], 182);
        wait_idle(t);
        check("b2b_wr_cnt", wr_total - base, 540);

        // reset while row 50 is on the write port
        base  = wr_total;
        dbase = done_total;
        send(5, 60, 0, 1, 1, t);
        for (int i = 0; i < 200 && cyc < t + 52; i++) @(negedge pixel_clk_in);
        check("mid_we",   fb_we_out, 1);
        check("mid_addr", fb_addr_out, 5 + 320 * 50);
        rst_in = 1'b1;
        @(negedge pixel_clk_in);
        check("abort_we",   fb_we_out, 0);
        check("abort_busy", busy_out, 0);
        @(negedge pixel_clk_in);
        rst_in = 1'b0;
        @(negedge pixel_clk_in);
        check("abort_tready", dda_fifo_tready, 1);
        check("abort_addr",   fb_addr_out, 0);
        check("abort_data",   fb_data_out, 0);
        repeat (5) @(negedge pixel_clk_in);
        check("abort_wr_cnt", wr_total - base, 51);
        check("abort_done",   done_total - dbase, 0);

        run_col("recover", 100, 60, 0, 5, 0, 60, 120, 16'hFFE0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
